pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined carry-propagate adder/subtractor. Successor to the single-bit full adder cell.
- Splits a WIDTH-bit add into STAGES chunks of WIDTH/STAGES bits. One chunk is resolved per clock, and the carry is registered between stages.
- Used as the final carry-propagate stage after the Wallace-tree reduction, and as a general adder at high clock rates.
- Valid/ready handshake on input and output.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages. Each stage adds CHUNK = WIDTH/STAGES bits. STAGES=1 gives a single registered adder.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) or borrow-in (sub)
- sub  input  1  0: s = a + b + cin. 1: s = a - b - cin.
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- s  output  WIDTH  sum/difference
- cout  output  1  carry-out of the MSB (sub: 1 = no borrow)

Behaviour:
- Reset is asynchronous, active-high. While rst=1:
  - all stage valid flags clear, so out_valid=0;
  - s=0, cout=0, all pipeline data registers 0;
  - in_ready=1 once rst deasserts.
- Reset mid-operation discards every in-flight beat. No stale result appears after reset.
- Operand conditioning at entry:
  - effective B = b XOR {WIDTH{sub}};
  - effective carry-in = cin XOR sub;
  - so sub=1 computes a + ~b + !cin, all WIDTH-bit modular.
- Stage k (0..STAGES-1):
  - adds chunk k of A and effective B, plus the registered carry from stage k-1 (stage 0 uses effective carry-in);
  - registers a CHUNK-bit partial sum and a carry;
  - upper, not-yet-added operand chunks travel forward in skew registers;
  - lower, already-computed sum chunks travel forward in deskew registers.
- Latency: a beat accepted at edge N appears on s/cout with out_valid=1 after edge N+STAGES. Latency is exactly STAGES cycles when not stalled.
- Throughput: one beat per cycle.
- Advance enable: adv = ~out_valid | out_ready.
  - All stages shift only when adv=1. This is a global stall; internal bubbles are not collapsed.
  - in_ready = adv, combinational from out_valid and out_ready.
- A beat is accepted when in_valid & in_ready. When adv=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Stall: while out_valid=1 & out_ready=0, the outputs s/cout/out_valid and all internal state hold. in_valid is ignored (in_ready=0).
- Simultaneous out_ready and in_valid on a full pipe: the head beat retires and the new beat enters in the same edge. No loss, no duplication.
- Data registers for bubble stages may hold don't-care values. s/cout are only meaningful when out_valid=1. After reset they are 0.
- cout is the carry out of the last stage, aligned with s.

Optional Feature:
- Macro: PIPELINED_ADDER_OVF_EN.
- Defined:
  - adds output port ovf (1 bit), aligned with s/out_valid;
  - ovf=1 when the two's-complement result overflows, i.e. the MSB-stage carry-in XOR cout;
  - reset value 0; held during stall like s.
- Not defined: port ovf is absent and no extra logic is generated.

Test Plan (WIDTH=16, STAGES=4):
- Wrap: a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 → 4 cycles later out_valid=1, s=0x0000, cout=1.
- Subtract:
  - a=0x1234, b=0x0235, sub=1, cin=0 → s=0x0FFF, cout=1.
  - a=0x0000, b=0x0001, sub=1 → s=0xFFFF, cout=0.
  - a=0x0010, b=0x0001, sub=1, cin=1 → s=0x000E.
- Streaming: 8 back-to-back beats (a=i, b=0x0100·i, i=0..7), out_ready=1 → results on 8 consecutive cycles starting at cycle 4, each s=0x0101·i.
- Stall: hold out_ready=0 for 3 cycles while out_valid=1 with 3 beats queued behind → in_ready=0, s/cout stable, then release → all beats delivered in order, none lost or repeated.
- Reset mid-flight: assert rst with 3 beats in flight → out_valid=0 immediately and s=0. After release, no result emerges for 4 cycles without new input.
- Overflow (macro defined): a=0x7FFF, b=0x0001 add → ovf=1. a=0x8000, b=0x0001 sub → ovf=1. a=0x0001, b=0x0001 add → ovf=0.

Source files
------------

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//
// Pipelined carry-propagate adder/subtractor. A WIDTH-bit operation is split
// into STAGES chunks of CHUNK = WIDTH/STAGES bits. Stage k resolves chunk k and
// registers its partial sum and carry. Operand chunks not yet added ride along
// in skew registers, and finished sum chunks ride along in deskew registers.
// The whole pipe advances together under a valid/ready handshake.
//
// Subtraction is a + ~b + !cin. That is, B is inverted and the carry-in is
// flipped at entry, so the stages only ever add.
//
// Parameters:
//   WIDTH   operand/sum width in bits; must be a multiple of STAGES
//   STAGES  pipeline depth; STAGES=1 gives a single registered adder
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous reset, active-high
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle (combinational)
//   a, b       operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: s = a + b + cin, 1: s = a - b - cin
//   out_valid  result beat valid
//   out_ready  downstream accepts result
//   s          sum/difference
//   cout       carry-out of the MSB (sub: 1 = no borrow)
//   ovf        two's-complement overflow, aligned with s
//              (present only with PIPELINED_ADDER_OVF_EN)
//
// Optional feature macro: PIPELINED_ADDER_OVF_EN adds the ovf output.
// -----------------------------------------------------------------------------
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
`ifdef PIPELINED_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CHUNK = WIDTH / STAGES;

  // The stall is global. Every stage moves only when the output slot is empty
  // or is being drained, so bubbles inside the pipe are not collapsed.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    localparam int LO  = k * CHUNK;   // sum bits already resolved upstream
    localparam int REM = WIDTH - LO;  // operand bits still to be added

    logic [REM-1:0]      op_a;
    logic [REM-1:0]      op_b;
    logic                c_in;
    logic                v_in;
    logic [CHUNK:0]      chunk_sum;
    logic [LO+CHUNK-1:0] sum_in;

    logic                valid_d, valid_q;
    logic                carry_d, carry_q;
    logic [LO+CHUNK-1:0] sum_d,   sum_q;

    assign chunk_sum = {1'b0, op_a[CHUNK-1:0]}
                     + {1'b0, op_b[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, c_in};

    if (k == 0) begin : g_src
      // Operand conditioning: subtraction becomes addition of ~b with the
      // carry-in flipped.
      assign op_a   = a;
      assign op_b   = b ^ {WIDTH{sub}};
      assign c_in   = cin ^ sub;
      assign v_in   = in_valid;
      assign sum_in = chunk_sum[CHUNK-1:0];
    end else begin : g_src
      assign op_a   = gen_stage[k-1].g_skew.a_sk_q;
      assign op_b   = gen_stage[k-1].g_skew.b_sk_q;
      assign c_in   = gen_stage[k-1].carry_q;
      assign v_in   = gen_stage[k-1].valid_q;
      // The new chunk goes above the deskewed lower chunks.
      assign sum_in = {chunk_sum[CHUNK-1:0], gen_stage[k-1].sum_q};
    end

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      if (adv) begin
        valid_d = v_in;
        carry_d = chunk_sum[CHUNK];
        sum_d   = sum_in;
      end
    end

    // NOTE: the data registers are reset along with the valid flags, so s/cout
    // read 0 after reset rather than whatever was in flight.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else begin
        // NOTE: state is updated with non-blocking assignments, so each stage
        // samples its neighbour's value from before the clock edge.
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    // Skew registers carry the operand chunks that later stages still have to
    // add. The last stage has none.
    if (k < STAGES - 1) begin : g_skew
      logic [REM-CHUNK-1:0] a_sk_d, a_sk_q;
      logic [REM-CHUNK-1:0] b_sk_d, b_sk_q;

      always_comb begin
        a_sk_d = a_sk_q;
        b_sk_d = b_sk_q;
        if (adv) begin
          a_sk_d = op_a[REM-1:CHUNK];
          b_sk_d = op_b[REM-1:CHUNK];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_sk_q <= '0;
          b_sk_q <= '0;
        end else begin
          a_sk_q <= a_sk_d;
          b_sk_q <= b_sk_d;
        end
      end
    end
  end

  assign out_valid = gen_stage[STAGES-1].valid_q;
  assign s         = gen_stage[STAGES-1].sum_q;
  assign cout      = gen_stage[STAGES-1].carry_q;

`ifdef PIPELINED_ADDER_OVF_EN
  // Overflow = carry into the MSB XOR carry out of the MSB. The carry into the
  // MSB is recovered as a ^ b ^ sum at that bit.
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    if (adv) begin
      ovf_d = gen_stage[STAGES-1].op_a[CHUNK-1]
            ^ gen_stage[STAGES-1].op_b[CHUNK-1]
            ^ gen_stage[STAGES-1].chunk_sum[CHUNK-1]
            ^ gen_stage[STAGES-1].chunk_sum[CHUNK];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef PIPELINED_ADDER_OVF_EN
  logic             ovf;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
`ifdef PIPELINED_ADDER_OVF_EN
    .ovf      (ovf),
`endif
    .cout     (cout)
  );

  // Reference: plain WIDTH+1-bit arithmetic, independent of the chunking.
  function automatic exp_t model(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                                 input logic ci, input logic si);
    exp_t             m;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] be;
    be     = si ? ~bi : bi;
    r      = {1'b0, ai} + {1'b0, be} + {{WIDTH{1'b0}}, ci ^ si};
    m.s    = r[WIDTH-1:0];
    m.cout = r[WIDTH];
    m.ovf  = (ai[WIDTH-1] == be[WIDTH-1]) && (r[WIDTH-1] != ai[WIDTH-1]);
    return m;
  endfunction

  // One clock: record handshakes seen just before the edge, then advance.
  task automatic step();
    logic acc_in, acc_out;
    exp_t e;
    #1;
    acc_in  = in_valid && in_ready;
    acc_out = out_valid && out_ready;
    if (acc_out) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got s=%h cout=%b, required no beat", s, cout);
      end else begin
        e = sb.pop_front();
        if ({s, cout} !== {e.s, e.cout}) begin
          errors++;
          $display("FAIL result: got s=%h cout=%b, required s=%h cout=%b", s, cout, e.s, e.cout);
        end
`ifdef PIPELINED_ADDER_OVF_EN
        if (ovf !== e.ovf) begin
          errors++;
          $display("FAIL ovf: got %b, required %b (s=%h)", ovf, e.ovf, e.s);
        end
`endif
      end
    end
    if (acc_in) sb.push_back(model(a, b, cin, sub));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                      input logic ci, input logic si);
    int n;
    n = 0;
    a = ai; b = bi; cin = ci; sub = si; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats still pending, required 0", sb.size());
    end
    // Anything emerging now would be a duplicate or a stale beat.
    repeat (STAGES + 1) step();
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    checks++;
    if (s !== '0 || cout !== 1'b0) begin
      errors++; $display("FAIL reset_data: got s=%h cout=%b, required s=0000 cout=0", s, cout);
    end
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_wrap();
    int n;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n != STAGES) begin
      errors++; $display("FAIL latency: got %0d cycles, required %0d", n, STAGES);
    end
    checks++;
    if (s !== 16'h0000 || cout !== 1'b1) begin
      errors++; $display("FAIL wrap: got s=%h cout=%b, required s=0000 cout=1", s, cout);
    end
    drain();
  endtask

  task automatic test_subtract();
    send(16'h1234, 16'h0235, 1'b0, 1'b1);
    send(16'h0000, 16'h0001, 1'b0, 1'b1);
    send(16'h0010, 16'h0001, 1'b1, 1'b1);
    send(16'h8000, 16'h8000, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] bi;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== (i >= STAGES)) begin
        errors++;
        $display("FAIL stream_valid: beat %0d got out_valid=%b, required %b", i, out_valid, i >= STAGES);
      end
      bi = 16'h0100 * i[WIDTH-1:0];
      send(i[WIDTH-1:0], bi, 1'b0, 1'b0);
    end
    drain();
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] hold_s;
    logic             hold_c;
    for (int i = 0; i < 4; i++) send(16'h1111 * i[WIDTH-1:0], 16'h0F0F, 1'b1, 1'b0);
    out_ready = 1'b0;
    a = 16'hABCD; b = 16'h1234; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    #1;
    hold_s = s;
    hold_c = cout;
    checks++;
    if (out_valid !== 1'b1 || sb.size() != 4 || hold_s !== sb[0].s) begin
      errors++;
      $display("FAIL stall_head: got out_valid=%b s=%h pending=%0d, required 1 with 4 pending",
               out_valid, hold_s, sb.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || s !== hold_s || cout !== hold_c) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got in_ready=%b out_valid=%b s=%h cout=%b, required 0 1 %h %b",
                 i, in_ready, out_valid, s, cout, hold_s, hold_c);
      end
      step();
    end
    // Release with a beat waiting: head retires and new beat enters together.
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 4; i++) send(16'h0101 + i[WIDTH-1:0], 16'h2020, 1'b0, 1'b0);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || s !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL midflight_reset: got out_valid=%b s=%h cout=%b, required 0 0000 0", out_valid, s, cout);
    end
    sb.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL stale_after_reset: cycle %0d got out_valid=%b, required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      a         = WIDTH'($urandom);
      b         = WIDTH'($urandom);
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();
  endtask

`ifdef PIPELINED_ADDER_OVF_EN
  task automatic test_overflow();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    send(16'h0001, 16'h0001, 1'b0, 1'b0);
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_subtract();
    test_streaming();
    test_stall();
    test_reset_midflight();
    test_random();
`ifdef PIPELINED_ADDER_OVF_EN
    test_overflow();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
